hdmi_i2c_responder: RTL



---
 rtl/hdmi_i2c_pkg.sv | 27 ++
 rtl/hdmi_i2c_resp_regfile.sv | 34 +++
 rtl/hdmi_i2c_responder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_i2c_pkg.sv
// Shared definitions for the HDMI transmitter I2C configuration path:
// responder FSM states, default target address and ADV7513 register indices.
package hdmi_i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } state_t;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h39;

  // ADV7513 register indices shared with the configuration controller
  localparam logic [7:0] ADV_REG_VID_IN_CFG = 8'h15;
  localparam logic [7:0] ADV_REG_VID_STYLE  = 8'h16;
  localparam logic [7:0] ADV_REG_POWER      = 8'h41;
  localparam logic [7:0] ADV_REG_FIXED_98   = 8'h98;
  localparam logic [7:0] ADV_REG_HDMI_MODE  = 8'hAF;
  localparam logic [7:0] ADV_REG_HPD_CTRL   = 8'hD6;

endpackage

// File: rtl/hdmi_i2c_resp_regfile.sv
// 256x8 register file behind the I2C responder: one synchronous write port,
// asynchronous bus and debug read ports, synchronous reset to REG_RESET.
module hdmi_i2c_resp_regfile
  import hdmi_i2c_pkg::*;
#(
  parameter logic [7:0] REG_RESET = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_en,
  input  logic [7:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  input  logic [7:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  input  logic [7:0] i_dbg_addr,
  output logic [7:0] o_dbg_data
);

  logic [7:0] r_mem [0:255];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 256; i++) begin
        r_mem[i[7:0]] <= REG_RESET;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data  = r_mem[i_rd_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/hdmi_i2c_responder.sv
// I2C target modelling the HDMI transmitter configuration port: oversamples
// SCL/SDA on CLK, ACKs its address, stores writes and serves reads.
module hdmi_i2c_responder
  import hdmi_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEFAULT,
  parameter logic [7:0] REG_RESET = 8'h00
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OE,
  output logic       REG_WR,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       BUSY,
  input  logic [7:0] DBG_ADDR,
  output logic [7:0] DBG_DATA
);

  logic       r_scl_s1, r_scl_s2, r_scl_d;
  logic       r_sda_s1, r_sda_s2, r_sda_d;
  state_t     r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_ptr;
  logic       r_rw;
  logic       r_ack_on;
  logic       r_sda_oe;
  logic       r_busy;
  logic       r_reg_wr;
  logic [7:0] r_reg_addr;
  logic [7:0] r_reg_wdata;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_last_bit;
  logic [7:0] w_byte;
  logic [7:0] w_rd_data;

  // Idle-high reset of the synchronizers avoids a phantom START/STOP after reset
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= SCL_IN;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= SDA_IN;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_byte     = {r_shift[6:0], r_sda_s2};
  assign w_last_bit = (r_bit_cnt == 3'd7);

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_ptr       <= 8'h00;
      r_rw        <= 1'b0;
      r_ack_on    <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_reg_addr  <= 8'h00;
      r_reg_wdata <= 8'h00;
    end else begin
      r_reg_wr <= 1'b0;
      if (w_start) begin
        r_state   <= ST_ADDR;
        r_bit_cnt <= 3'd0;
        r_ack_on  <= 1'b0;
        r_sda_oe  <= 1'b0;
      end else if (w_stop) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= 3'd0;
        r_ack_on  <= 1'b0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: ;
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_bit_cnt <= 3'd0;
                if (r_state == ST_ADDR) begin
                  if (w_byte[7:1] == DEV_ADDR) begin
                    r_state <= ST_ADDR_ACK;
                    r_rw    <= w_byte[0];
                    r_busy  <= 1'b1;
                  end else begin
                    r_state <= ST_IDLE;
                  end
                end else if (r_state == ST_PTR) begin
                  r_ptr   <= w_byte;
                  r_state <= ST_PTR_ACK;
                end else begin
                  r_reg_wr    <= 1'b1;
                  r_reg_addr  <= r_ptr;
                  r_reg_wdata <= w_byte;
                  r_ptr       <= r_ptr + 8'd1;
                  r_state     <= ST_WDATA_ACK;
                end
              end
            end
          end
          // First falling edge asserts ACK, second one ends the slot
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_on) begin
                r_sda_oe <= 1'b1;
                r_ack_on <= 1'b1;
              end else begin
                r_ack_on  <= 1'b0;
                r_bit_cnt <= 3'd0;
                if (r_state == ST_ADDR_ACK && r_rw) begin
                  r_state  <= ST_RDATA;
                  r_shift  <= w_rd_data;
                  r_sda_oe <= ~w_rd_data[7];
                end else begin
                  r_sda_oe <= 1'b0;
                  r_state  <= (r_state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                end
              end
            end
          end
          ST_RDATA: begin
            if (w_scl_rise) begin
              if (w_last_bit) begin
                r_bit_cnt <= 3'd0;
                r_state   <= ST_RDATA_ACK;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= {r_shift[6:0], 1'b0};
              end
            end else if (w_scl_fall) begin
              r_sda_oe <= ~r_shift[7];
            end
          end
          // r_ack_on marks a controller ACK; the reload happens once ptr has advanced
          ST_RDATA_ACK: begin
            if (w_scl_rise) begin
              if (!r_sda_s2) begin
                r_ptr    <= r_ptr + 8'd1;
                r_ack_on <= 1'b1;
              end else begin
                r_state  <= ST_IDLE;
                r_sda_oe <= 1'b0;
              end
            end else if (w_scl_fall) begin
              if (r_ack_on) begin
                r_state  <= ST_RDATA;
                r_shift  <= w_rd_data;
                r_sda_oe <= ~w_rd_data[7];
                r_ack_on <= 1'b0;
              end else begin
                r_sda_oe <= 1'b0;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  hdmi_i2c_resp_regfile #(
    .REG_RESET (REG_RESET)
  ) u_regfile (
    .i_clk      (CLK),
    .i_rst_n    (RST_n),
    .i_wr_en    (r_reg_wr),
    .i_wr_addr  (r_reg_addr),
    .i_wr_data  (r_reg_wdata),
    .i_rd_addr  (r_ptr),
    .o_rd_data  (w_rd_data),
    .i_dbg_addr (DBG_ADDR),
    .o_dbg_data (DBG_DATA)
  );

  assign SDA_OE    = r_sda_oe;
  assign REG_WR    = r_reg_wr;
  assign REG_ADDR  = r_reg_addr;
  assign REG_WDATA = r_reg_wdata;
  assign BUSY      = r_busy;

endmodule
